// File: rtl/mem_io_sequencer_pkg.sv
// Shared types and constants for the load/store sequencer and the core wrapper.
// Address decode: the top 1 KiB of the 32-bit space is the memory-mapped I/O window.
package memio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_IO_ACC,
    ST_RESP
  } state_e;

  localparam logic [21:0] IO_BASE_HI = 22'h3FFFFF;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  function automatic logic is_io(input logic [31:0] addr);
    return (addr >> 10) == {10'b0, IO_BASE_HI};
  endfunction

endpackage

// File: rtl/mem_io_sequencer.sv
// Load/store sequencer: mem store 2 cycles, mem load MEM_LAT+2, I/O ack or IO_TIMEOUT+1.
// Accepts only in IDLE; stalls the core for the whole access including the RESP cycle.
module mem_io_sequencer
  import memio_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int MEM_AW     = 14,
  parameter int IO_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              io_rd,
  output logic              io_wr,
  output logic [9:0]        io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack
);

  localparam int CNT_W = $clog2(IO_TIMEOUT + MEM_LAT + 1);

  state_e            r_state;
  state_e            w_next;
  logic              r_write;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [9:0]        r_io_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic              r_io_rd;
  logic              r_io_wr;

  logic w_idle;
  logic w_accept;
  logic w_to_io;
  logic w_mem_done;
  logic w_io_tmo;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = req_valid && w_idle;
  assign w_to_io    = is_io(req_addr);
  assign w_mem_done = (r_cnt == CNT_W'(MEM_LAT));
  assign w_io_tmo   = (r_cnt == CNT_W'(IO_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_to_io)        w_next = ST_IO_ACC;
          else if (req_write) w_next = ST_MEM_WR;
          else                w_next = ST_MEM_RD;
        end
      end
      ST_MEM_WR: w_next = ST_RESP;
      ST_MEM_RD: if (w_mem_done) w_next = ST_RESP;
      ST_IO_ACC: if (io_ack || w_io_tmo) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Strobes are computed one cycle ahead so they leave straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write    <= 1'b0;
      r_mem_addr <= '0;
      r_io_addr  <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_io_rd    <= 1'b0;
      r_io_wr    <= 1'b0;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write    <= req_write;
            r_mem_addr <= req_addr[MEM_AW+1:2];
            r_io_addr  <= req_addr[9:0];
            r_wdata    <= req_wdata;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            if (w_to_io) begin
              r_io_rd <= !req_write;
              r_io_wr <= req_write;
            end else begin
              r_mem_en <= 1'b1;
              r_mem_we <= req_write;
            end
          end
        end
        ST_MEM_RD: begin
          if (w_mem_done) r_rdata <= mem_rdata;
          else            r_cnt   <= r_cnt + CNT_W'(1);
        end
        ST_IO_ACC: begin
          // A late ack on the timeout cycle still counts as success.
          if (io_ack) begin
            if (!r_write) r_rdata <= io_rdata;
            r_io_rd <= 1'b0;
            r_io_wr <= 1'b0;
          end else if (w_io_tmo) begin
            r_err   <= 1'b1;
            r_io_rd <= 1'b0;
            r_io_wr <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = w_idle;
  assign stall      = w_accept || !w_idle;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = resp_valid ? r_rdata : 32'h0;
  assign resp_err   = resp_valid && r_err;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_wdata;
  assign io_rd      = r_io_rd;
  assign io_wr      = r_io_wr;
  assign io_addr    = r_io_addr;
  assign io_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_io_sequencer.sv
// Directed bench for mem_io_sequencer with a MEM_LAT=2 BRAM model and a scripted I/O device.
module tb_mem_io_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, stall, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        io_rd, io_wr;
  logic [9:0]  io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic        io_ack;

  int n_tests = 0;
  int n_fail  = 0;

  mem_io_sequencer #(.MEM_LAT(2), .MEM_AW(14), .IO_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
  );

  always #5 clk = ~clk;

  // BRAM model: read data appears for exactly one cycle, two cycles after the enable edge.
  logic [31:0] bram [0:255];
  logic [31:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    if (!rst_n) begin
      bram[8'h20] <= 32'h1111_2222;
      bram[8'h21] <= 32'h3333_4444;
    end else if (mem_en && mem_we) begin
      bram[mem_addr[7:0]] <= mem_wdata;
    end
    rd_p0 <= (mem_en && !mem_we) ? bram[mem_addr[7:0]] : 32'h0;
    rd_p1 <= rd_p0;
  end
  assign mem_rdata = rd_p1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and follows it to resp_valid, recording what the targets saw.
  task automatic run_access(
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  int          ack_at,
    input  logic [31:0] ack_data,
    output int          lat,
    output int          n_mem_en,
    output int          n_io,
    output logic        seen_we,
    output logic        seen_iow,
    output logic [31:0] seen_addr,
    output logic [31:0] seen_wdata,
    output logic [31:0] rd,
    output logic        err,
    output logic        stall_ok
  );
    logic got;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; io_ack = 1'b0;
    lat = 0; n_mem_en = 0; n_io = 0; seen_we = 1'b0; seen_iow = 1'b0;
    seen_addr = '0; seen_wdata = '0; rd = 32'hX; err = 1'bX; got = 1'b0;
    #1;
    stall_ok = stall;
    while (!got && lat < 40) begin
      tick();
      lat++;
      req_valid = 1'b0;
      io_ack = 1'b0;
      if (!stall) stall_ok = 1'b0;
      if (mem_en) begin
        n_mem_en++; seen_we = mem_we; seen_addr = {18'b0, mem_addr}; seen_wdata = mem_wdata;
      end
      if (io_rd || io_wr) begin
        n_io++; seen_iow = io_wr; seen_addr = {22'b0, io_addr}; seen_wdata = io_wdata;
      end
      if (resp_valid) begin
        got = 1'b1; rd = resp_rdata; err = resp_err;
      end else if (lat == ack_at) begin
        io_ack = 1'b1; io_rdata = ack_data;
      end
    end
    if (!got) lat = -1;
  endtask

  int          lat, n_mem_en, n_io;
  logic        seen_we, seen_iow, err, stall_ok;
  logic [31:0] seen_addr, seen_wdata, rd;

  task automatic test_reset();
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_tests++; if ({mem_en, mem_we, io_rd, io_wr} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {mem_en, mem_we, io_rd, io_wr}); end
    n_tests++; if (mem_addr !== 14'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
  endtask

  task automatic test_mem_store();
    run_access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 32'h0, lat, n_mem_en, n_io, seen_we, seen_iow, seen_addr, seen_wdata, rd, err, stall_ok);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL store_latency: got %0d expected 2", lat); end
    n_tests++; if (n_mem_en !== 1 || seen_we !== 1'b1) begin n_fail++; $display("FAIL store_strobe: got en_cycles %0d we %b expected 1 1", n_mem_en, seen_we); end
    n_tests++; if (seen_addr !== 32'h10) begin n_fail++; $display("FAIL store_mem_addr: got %h expected 10", seen_addr); end
    n_tests++; if (seen_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_wdata: got %h expected deadbeef", seen_wdata); end
    n_tests++; if (rd !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL store_resp: got rdata %h err %b expected 0 0", rd, err); end
    n_tests++; if (n_io !== 0) begin n_fail++; $display("FAIL store_no_io: got %0d io cycles expected 0", n_io); end
    tick();
    n_tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL store_back_idle: got ready %b valid %b expected 1 0", req_ready, resp_valid); end
  endtask

  task automatic test_mem_load();
    run_access(1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, lat, n_mem_en, n_io, seen_we, seen_iow, seen_addr, seen_wdata, rd, err, stall_ok);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL load_latency: got %0d expected 4", lat); end
    n_tests++; if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin n_fail++; $display("FAIL load_data: got %h err %b expected deadbeef 0", rd, err); end
    n_tests++; if (n_mem_en !== 1 || seen_we !== 1'b0) begin n_fail++; $display("FAIL load_strobe: got en_cycles %0d we %b expected 1 0", n_mem_en, seen_we); end
    n_tests++; if (stall_ok !== 1'b1) begin n_fail++; $display("FAIL load_stall: got %b expected 1 throughout", stall_ok); end
    tick();
    // Low address bits are ignored for memory: 0x43 hits the same word.
    run_access(1'b0, 32'h0000_0043, 32'h0, 0, 32'h0, lat, n_mem_en, n_io, seen_we, seen_iow, seen_addr, seen_wdata, rd, err, stall_ok);
    n_tests++; if (seen_addr !== 32'h10 || rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_unaligned: got addr %h data %h expected 10 deadbeef", seen_addr, rd); end
    tick();
  endtask

  task automatic test_io_read();
    run_access(1'b0, 32'hFFFF_FC70, 32'h0, 3, 32'h0000_00A5, lat, n_mem_en, n_io, seen_we, seen_iow, seen_addr, seen_wdata, rd, err, stall_ok);
    n_tests++; if (n_io !== 3 || seen_iow !== 1'b0) begin n_fail++; $display("FAIL io_rd_strobe: got %0d cycles wr %b expected 3 0", n_io, seen_iow); end
    n_tests++; if (seen_addr !== 32'h070) begin n_fail++; $display("FAIL io_rd_addr: got %h expected 070", seen_addr); end
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL io_rd_latency: got %0d expected 4", lat); end
    n_tests++; if (rd !== 32'hA5 || err !== 1'b0) begin n_fail++; $display("FAIL io_rd_resp: got %h err %b expected a5 0", rd, err); end
    n_tests++; if (n_mem_en !== 0) begin n_fail++; $display("FAIL io_rd_no_mem: got %0d expected 0", n_mem_en); end
    tick();
  endtask

  task automatic test_io_timeout();
    run_access(1'b1, 32'hFFFF_FC60, 32'h1234_5678, 0, 32'h0, lat, n_mem_en, n_io, seen_we, seen_iow, seen_addr, seen_wdata, rd, err, stall_ok);
    n_tests++; if (n_io !== 16 || seen_iow !== 1'b1) begin n_fail++; $display("FAIL tmo_strobe: got %0d cycles wr %b expected 16 1", n_io, seen_iow); end
    n_tests++; if (seen_addr !== 32'h060 || seen_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL tmo_addr_data: got %h %h expected 060 12345678", seen_addr, seen_wdata); end
    n_tests++; if (lat !== 17 || err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL tmo_resp: got lat %0d err %b rd %h expected 17 1 0", lat, err, rd); end
    tick();
    run_access(1'b1, 32'hFFFF_FC60, 32'h1234_5678, 16, 32'hCAFE_0001, lat, n_mem_en, n_io, seen_we, seen_iow, seen_addr, seen_wdata, rd, err, stall_ok);
    n_tests++; if (n_io !== 16 || lat !== 17) begin n_fail++; $display("FAIL ack16_timing: got %0d cycles lat %0d expected 16 17", n_io, lat); end
    n_tests++; if (err !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL ack16_resp: got err %b rd %h expected 0 0", err, rd); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic saw_resp;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hFFFF_FC70; req_wdata = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    n_tests++; if (io_rd !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got io_rd %b expected 1", io_rd); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (io_rd !== 1'b0 || io_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_strobe: got %b%b expected 00", io_rd, io_wr); end
    n_tests++; if (stall !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_flow: got stall %b ready %b expected 0 1", stall, req_ready); end
    #4 rst_n = 1'b1;
    saw_resp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp_valid || io_rd) saw_resp = 1'b1;
    end
    n_tests++; if (saw_resp !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_resp: got activity %b expected 0", saw_resp); end
  endtask

  task automatic test_back_to_back();
    int          cyc, n_resp, n_en;
    int          r_cyc [2];
    logic [31:0] r_dat [2];
    logic        rdy_in_resp, rdy5;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0080; req_wdata = 32'h0;
    cyc = 0; n_resp = 0; n_en = 0; rdy_in_resp = 1'b0; rdy5 = 1'b0;
    r_cyc[0] = -1; r_cyc[1] = -1; r_dat[0] = '0; r_dat[1] = '0;
    while (n_resp < 2 && cyc < 60) begin
      tick();
      cyc++;
      if (mem_en) n_en++;
      if (cyc == 5) rdy5 = req_ready;
      if (resp_valid) begin
        if (req_ready) rdy_in_resp = 1'b1;
        r_cyc[n_resp] = cyc; r_dat[n_resp] = resp_rdata;
        n_resp++;
        req_addr = 32'h0000_0084;
      end
    end
    req_valid = 1'b0;
    n_tests++; if (r_cyc[0] !== 4 || r_cyc[1] !== 9) begin n_fail++; $display("FAIL b2b_timing: got %0d %0d expected 4 9", r_cyc[0], r_cyc[1]); end
    n_tests++; if (r_dat[0] !== 32'h1111_2222 || r_dat[1] !== 32'h3333_4444) begin n_fail++; $display("FAIL b2b_data: got %h %h expected 11112222 33334444", r_dat[0], r_dat[1]); end
    n_tests++; if (n_en !== 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", n_en); end
    n_tests++; if (rdy_in_resp !== 1'b0 || rdy5 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got resp %b idle %b expected 0 1", rdy_in_resp, rdy5); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    io_ack = 1'b0; io_rdata = '0;
    #23 rst_n = 1'b1;
    tick();
    test_reset();
    test_mem_store();
    test_mem_load();
    test_io_read();
    test_io_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
